// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The producer/consumer side uses master; the adder uses slave.
interface serial_adder_if #(
  parameter int NBITS = 32
);
  logic             in_val;
  logic             in_rdy;
  logic [NBITS-1:0] in0;
  logic [NBITS-1:0] in1;
  logic             cin;
  logic             out_val;
  logic             out_rdy;
  logic [NBITS-1:0] sum;
  logic             cout;

  modport master (
    output in_val, in0, in1, cin, out_rdy,
    input  in_rdy, out_val, sum, cout
  );

  modport slave (
    input  in_val, in0, in1, cin, out_rdy,
    output in_rdy, out_val, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial NBITS-bit adder: one full-adder cell plus a carry flop, LSB first.
// Accepts operands in IDLE, spends NBITS cycles in CALC, then presents the result in DONE.
module serial_adder #(
  parameter int NBITS = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [NBITS-1:0] a_reg;
  logic [NBITS-1:0] b_reg;
  logic [NBITS-1:0] result_reg;
  logic             carry_reg;
  logic [CW-1:0]    count_reg;
  logic             in_rdy_reg;
  logic             out_val_reg;

  logic sum_bit;
  logic carry_next;

  // The single full-adder cell, always looking at the current LSBs.
  assign sum_bit    = a_reg[0] ^ b_reg[0] ^ carry_reg;
  assign carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      result_reg  <= '0;
      carry_reg   <= 1'b0;
      count_reg   <= '0;
      in_rdy_reg  <= 1'b0;
      out_val_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          in_rdy_reg  <= 1'b1;
          out_val_reg <= 1'b0;
          if (bus.in_val && in_rdy_reg) begin
            a_reg      <= bus.in0;
            b_reg      <= bus.in1;
            carry_reg  <= bus.cin;
            result_reg <= '0;
            count_reg  <= '0;
            in_rdy_reg <= 1'b0;
            state_reg  <= CALC;
          end
        end
        CALC: begin
          a_reg      <= a_reg >> 1;
          b_reg      <= b_reg >> 1;
          result_reg <= {sum_bit, result_reg[NBITS-1:1]};
          carry_reg  <= carry_next;
          count_reg  <= count_reg + CW'(1);
          // After this edge all NBITS sum bits are in place and carry_reg is cout.
          if (count_reg == LAST_BIT) begin
            out_val_reg <= 1'b1;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          if (bus.out_rdy) begin
            out_val_reg <= 1'b0;
            in_rdy_reg  <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        default: begin
          in_rdy_reg  <= 1'b0;
          out_val_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_rdy  = in_rdy_reg;
  assign bus.out_val = out_val_reg;
  assign bus.sum     = result_reg;
  assign bus.cout    = carry_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed 32-bit cases, backpressure, reset abort,
// random 32-bit traffic and every 4-bit operand combination in shuffled order.
module tb_serial_adder;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  serial_adder_if #(.NBITS(32)) bus32 ();
  serial_adder_if #(.NBITS(4))  bus4 ();

  serial_adder #(.NBITS(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
  serial_adder #(.NBITS(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy32();
    int n = 0;
    while (bus32.in_rdy !== 1'b1 && n < 100) begin tick(); n++; end
    check_val("rdy32_timeout", 64'(n < 100), 64'd1);
  endtask

  // Waits for out_val, returns cycles since the accept edge; flags in_rdy seen high meanwhile.
  task automatic wait_out32(output int lat, output int rdy_seen);
    lat = 0;
    rdy_seen = 0;
    while (bus32.out_val !== 1'b1 && lat < 100) begin
      tick();
      lat++;
      if (bus32.in_rdy === 1'b1) rdy_seen++;
    end
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic c,
                      input int stall, input string tag);
    logic [32:0] ref_v;
    int lat, rdy_seen;
    ref_v = 33'(a) + 33'(b) + 33'(c);
    bus32.out_rdy = (stall == 0);
    bus32.in0 = a; bus32.in1 = b; bus32.cin = c; bus32.in_val = 1'b1;
    wait_rdy32();
    tick();
    bus32.in_val = 1'b0;
    bus32.in0 = $urandom; bus32.in1 = $urandom; bus32.cin = 1'($urandom);
    wait_out32(lat, rdy_seen);
    check_val({tag, "_lat"}, 64'(lat), 64'd32);
    check_val({tag, "_sum"}, 64'(bus32.sum), 64'(ref_v[31:0]));
    check_val({tag, "_cout"}, 64'(bus32.cout), 64'(ref_v[32]));
    for (int i = 0; i < stall; i++) begin
      tick();
      check_val({tag, "_hold_sum"}, 64'(bus32.sum), 64'(ref_v[31:0]));
      check_val({tag, "_hold_rdy"}, 64'(bus32.in_rdy), 64'd0);
      check_val({tag, "_hold_val"}, 64'(bus32.out_val), 64'd1);
    end
    bus32.out_rdy = 1'b1;
    tick();
    check_val({tag, "_post_val"}, 64'(bus32.out_val), 64'd0);
    check_val({tag, "_post_rdy"}, 64'(bus32.in_rdy), 64'd1);
    $display("%s a=%h b=%h cin=%0d stall=%0d sum=%h cout=%0d lat=%0d",
             tag, a, b, c, stall, bus32.sum, bus32.cout, lat);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c, input int stall);
    logic [4:0] ref_v;
    int n, lat;
    ref_v = 5'(a) + 5'(b) + 5'(c);
    bus4.out_rdy = (stall == 0);
    bus4.in0 = a; bus4.in1 = b; bus4.cin = c; bus4.in_val = 1'b1;
    n = 0;
    while (bus4.in_rdy !== 1'b1 && n < 50) begin tick(); n++; end
    check_val("rdy4_timeout", 64'(n < 50), 64'd1);
    tick();
    bus4.in_val = 1'b0;
    bus4.in0 = 4'($urandom); bus4.in1 = 4'($urandom);
    lat = 0;
    while (bus4.out_val !== 1'b1 && lat < 50) begin tick(); lat++; end
    check_val("op4_lat", 64'(lat), 64'd4);
    check_val("op4_sum", 64'(bus4.sum), 64'(ref_v[3:0]));
    check_val("op4_cout", 64'(bus4.cout), 64'(ref_v[4]));
    repeat (stall) tick();
    check_val("op4_hold_sum", 64'(bus4.sum), 64'(ref_v[3:0]));
    bus4.out_rdy = 1'b1;
    tick();
    check_val("op4_post_rdy", 64'(bus4.in_rdy), 64'd1);
    $display("op4 a=%h b=%h cin=%0d sum=%h cout=%0d lat=%0d", a, b, c, bus4.sum, bus4.cout, lat);
  endtask

  initial begin
    logic [32:0] exp_q[$];
    logic [32:0] exp_v;
    int lat, rdy_seen, val_seen;
    int idx[512];

    checks = 0;
    failures = 0;
    bus32.in_val = 1'b0; bus32.in0 = '0; bus32.in1 = '0; bus32.cin = 1'b0; bus32.out_rdy = 1'b1;
    bus4.in_val  = 1'b0; bus4.in0  = '0; bus4.in1  = '0; bus4.cin  = 1'b0; bus4.out_rdy  = 1'b1;
    rst_n = 1'b0;
    #22;
    check_val("rst_in_rdy", 64'(bus32.in_rdy), 64'd0);
    check_val("rst_out_val", 64'(bus32.out_val), 64'd0);
    check_val("rst_sum", 64'(bus32.sum), 64'd0);
    check_val("rst_cout", 64'(bus32.cout), 64'd0);
    rst_n = 1'b1;
    tick();
    check_val("rst_first_rdy", 64'(bus32.in_rdy), 64'd1);

    op32(32'd5, 32'd7, 1'b0, 0, "basic");
    op32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, "carry_cin");
    op32(32'h8000_0000, 32'h8000_0000, 1'b0, 0, "carry_msb");
    op32(32'h1234_5678, 32'h1111_1111, 1'b0, 10, "backpressure");

    // Back-to-back with in_val held: the second pair waits for the first handshake.
    bus32.out_rdy = 1'b1;
    bus32.in0 = 32'd1; bus32.in1 = 32'd1; bus32.cin = 1'b0; bus32.in_val = 1'b1;
    exp_q.push_back(33'd2);
    exp_q.push_back(33'(32'hFFFF_0000) + 33'(32'h0000_FFFF));
    wait_rdy32();
    tick();
    bus32.in0 = 32'hFFFF_0000; bus32.in1 = 32'h0000_FFFF;
    for (int k = 0; k < 2; k++) begin
      wait_out32(lat, rdy_seen);
      exp_v = exp_q.pop_front();
      check_val("b2b_lat", 64'(lat), 64'd32);
      check_val("b2b_no_accept", 64'(rdy_seen), 64'd0);
      check_val("b2b_sum", 64'(bus32.sum), 64'(exp_v[31:0]));
      check_val("b2b_cout", 64'(bus32.cout), 64'(exp_v[32]));
      $display("b2b result %0d sum=%h cout=%0d", k, bus32.sum, bus32.cout);
      tick();
      check_val("b2b_post_val", 64'(bus32.out_val), 64'd0);
      check_val("b2b_post_rdy", 64'(bus32.in_rdy), 64'd1);
      if (k == 0) begin
        tick();
        bus32.in_val = 1'b0;
      end
    end

    // Abort in CALC at counter 10 with a nonzero partial sum and carry set.
    bus32.in0 = 32'hFFFF_FFFF; bus32.in1 = 32'h0000_0002; bus32.cin = 1'b0; bus32.in_val = 1'b1;
    wait_rdy32();
    tick();
    bus32.in_val = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check_val("abort_out_val", 64'(bus32.out_val), 64'd0);
    check_val("abort_sum", 64'(bus32.sum), 64'd0);
    check_val("abort_cout", 64'(bus32.cout), 64'd0);
    check_val("abort_in_rdy", 64'(bus32.in_rdy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_val("abort_rdy_after", 64'(bus32.in_rdy), 64'd1);
    val_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus32.out_val === 1'b1) val_seen++;
    end
    check_val("abort_no_stale_val", 64'(val_seen), 64'd0);
    $display("abort done out_val_cycles=%0d", val_seen);

    for (int i = 0; i < 16; i++)
      op32($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)), "rand32");

    for (int i = 0; i < 512; i++) idx[i] = i;
    for (int i = 511; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(0, i));
      t = idx[i]; idx[i] = idx[j]; idx[j] = t;
    end
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(idx[i]);
      op4(v[3:0], v[7:4], v[8], int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
